// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion, one round key per handshake
module aes_key_schedule (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, PRESENT, SUB} state_t;

   // FIPS-197 forward S-box, indexed by input byte
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant for the round being produced (1..10)
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t         state_q;
   logic [1:0]     cnt_q;
   logic [127:0]   rk_q;
   logic [3:0]     round_q;
   logic           valid_q;
   logic           busy_q;
   logic           done_q;
   logic [23:0]    temp_q;

   logic [31:0]    rot_word;
   logic [7:0]     sbox_in;
   logic [7:0]     sbox_out;
   logic [31:0]    t_word;
   logic [31:0]    w0_d, w1_d, w2_d, w3_d;
   logic [127:0]   rk_d;

   // Shared S-box: feed byte cnt_q of RotWord(w3), byte 0 being the most significant
   always_comb begin
      rot_word = {rk_q[23:0], rk_q[31:24]};
      case (cnt_q)
         2'd0:    sbox_in = rot_word[31:24];
         2'd1:    sbox_in = rot_word[23:16];
         2'd2:    sbox_in = rot_word[15:8];
         default: sbox_in = rot_word[7:0];
      endcase
      sbox_out = SBOX[sbox_in];
   end

   // Next round key, valid on the last SUB cycle when the fourth S-box byte is live
   always_comb begin
      t_word = {temp_q, sbox_out} ^ {rcon(round_q + 4'd1), 24'h0};
      w0_d   = rk_q[127:96] ^ t_word;
      w1_d   = rk_q[95:64]  ^ w0_d;
      w2_d   = rk_q[63:32]  ^ w1_d;
      w3_d   = rk_q[31:0]   ^ w2_d;
      rk_d   = {w0_d, w1_d, w2_d, w3_d};
   end

   // Control FSM with registered outputs; reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         rk_q    <= '0;
         round_q <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         temp_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  rk_q    <= key_in;
                  round_q <= 4'd0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= PRESENT;
               end
            end
            PRESENT: begin
               if (rk_ready) begin
                  valid_q <= 1'b0;
                  if (round_q == 4'd10) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= 2'd0;
                     state_q <= SUB;
                  end
               end
            end
            SUB: begin
               if (cnt_q == 2'd3) begin
                  rk_q    <= rk_d;
                  round_q <= round_q + 4'd1;
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end else begin
                  case (cnt_q)
                     2'd0:    temp_q[23:16] <= sbox_out;
                     2'd1:    temp_q[15:8]  <= sbox_out;
                     default: temp_q[7:0]   <= sbox_out;
                  endcase
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rk       = rk_q;
   assign rk_round = round_q;
   assign rk_valid = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - bench for aes_key_schedule against a FIPS-197 word-expansion model
module tb_aes_key_schedule;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_valid;
   logic         rk_ready;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox_tab [256];
   logic [127:0] exp_rk [0:10];

   localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_key_schedule dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .rk       (rk),
      .rk_round (rk_round),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xtime(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
         if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   // Standard 44-word expansion, grouped into 11 round keys
   task automatic compute_keys(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h0};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // One full expansion; leaves the bench sitting in the done cycle
   task automatic run_keys(input string name, input logic [127:0] key, input int stall_round,
                           input int stall_cycles, input bit poke,
                           input logic [127:0] kr1, input logic [127:0] kr10);
      int cyc;
      int n;
      int extra;
      compute_keys(key);
      extra  = (stall_round >= 0) ? stall_cycles : 0;
      key_in = key;
      start  = 1'b1;
      step();
      start  = 1'b0;
      cyc    = 1;
      for (int r = 0; r <= 10; r++) begin
         n = 0;
         while (rk_valid !== 1'b1 && n < 20) begin
            if (poke) begin
               start  = 1'b1;
               key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            cyc++;
            n++;
         end
         start  = 1'b0;
         key_in = key;
         chk($sformatf("%s r%0d valid", name, r), 128'(rk_valid), 128'd1);
         chk($sformatf("%s r%0d round", name, r), 128'(rk_round), 128'(r));
         chk($sformatf("%s r%0d key", name, r), rk, exp_rk[r]);
         chk($sformatf("%s r%0d cycle", name, r), 128'(cyc),
             128'(1 + 5*r + ((stall_round >= 0 && r > stall_round) ? stall_cycles : 0)));
         chk($sformatf("%s r%0d busy", name, r), 128'(busy), 128'd1);
         if (r == 1 && kr1 != '0) chk($sformatf("%s r1 fips", name), rk, kr1);
         if (r == 10 && kr10 != '0) chk($sformatf("%s r10 fips", name), rk, kr10);
         if (r == stall_round) begin
            rk_ready = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               if (poke) begin
                  start  = 1'b1;
                  key_in = {$urandom, $urandom, $urandom, $urandom};
               end
               step();
               cyc++;
               chk($sformatf("%s stall%0d valid", name, s), 128'(rk_valid), 128'd1);
               chk($sformatf("%s stall%0d round", name, s), 128'(rk_round), 128'(r));
               chk($sformatf("%s stall%0d key", name, s), rk, exp_rk[r]);
            end
            start    = 1'b0;
            key_in   = key;
            rk_ready = 1'b1;
         end
         step();
         cyc++;
      end
      chk({name, " done"}, 128'(done), 128'd1);
      chk({name, " done busy"}, 128'(busy), 128'd0);
      chk({name, " done valid"}, 128'(rk_valid), 128'd0);
      chk({name, " done cycle"}, 128'(cyc), 128'(52 + extra));
      chk({name, " done key"}, rk, exp_rk[10]);
   endtask

   task automatic check_idle_after(input string name);
      step();
      chk({name, " done once"}, 128'(done), 128'd0);
      chk({name, " hold round"}, 128'(rk_round), 128'd10);
      chk({name, " hold key"}, rk, exp_rk[10]);
      chk({name, " idle valid"}, 128'(rk_valid), 128'd0);
   endtask

   initial begin
      int n;
      logic [127:0] rkey;
      rst      = 1'b1;
      start    = 1'b0;
      key_in   = '0;
      rk_ready = 1'b1;
      for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

      step();
      step();
      chk("reset rk", rk, '0);
      chk("reset round", 128'(rk_round), 128'd0);
      chk("reset valid", 128'(rk_valid), 128'd0);
      chk("reset busy", 128'(busy), 128'd0);
      chk("reset done", 128'(done), 128'd0);
      rst = 1'b0;
      step();

      run_keys("a1", KEY_A1, -1, 0, 1'b0, A1_R1, A1_R10);
      check_idle_after("a1");

      run_keys("bp", KEY_A1, 3, 7, 1'b0, A1_R1, A1_R10);
      check_idle_after("bp");

      run_keys("zero", '0, -1, 0, 1'b0, Z_R1, Z_R10);
      check_idle_after("zero");

      run_keys("poke", KEY_A1, 2, 3, 1'b1, A1_R1, A1_R10);
      check_idle_after("poke");

      // Abort in the middle of producing round 5
      key_in = KEY_A1;
      start  = 1'b1;
      step();
      start  = 1'b0;
      n = 0;
      while (!(rk_valid === 1'b1 && rk_round === 4'd4) && n < 40) begin
         step();
         n++;
      end
      chk("rst reach r4", 128'(rk_round), 128'd4);
      step();
      step();
      step();
      chk("rst in sub", 128'(rk_valid), 128'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst rk", rk, '0);
      chk("midrst round", 128'(rk_round), 128'd0);
      chk("midrst valid", 128'(rk_valid), 128'd0);
      chk("midrst busy", 128'(busy), 128'd0);
      chk("midrst done", 128'(done), 128'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("postrst%0d done", i), 128'(done), 128'd0);
         chk($sformatf("postrst%0d valid", i), 128'(rk_valid), 128'd0);
      end
      run_keys("after_rst", KEY_A1, -1, 0, 1'b0, A1_R1, A1_R10);

      // Second key starts in the done cycle of the first
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_keys("b2b", rkey, -1, 0, 1'b0, '0, '0);
      check_idle_after("b2b");

      for (int k = 0; k < 4; k++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         run_keys($sformatf("rnd%0d", k), rkey, int'($urandom_range(0, 10)),
                  int'($urandom_range(1, 6)), 1'(k % 2), '0, '0);
         check_idle_after($sformatf("rnd%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key-expansion engine that produces the eleven round keys (round 0..10) one at a time over a valid/ready stream. It feeds the AddRoundKey step that directly consumes the MixColumns output in the round datapath. It uses a single time-multiplexed byte S-box (4 cycles per round key) to keep area low.

## Interface
- No parameters; AES-128 only (fixed 128-bit key, 10 rounds).
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin expansion of key_in; sampled only in IDLE
- key_in  in  128  cipher key; [127:120] = byte 0, w0 = [127:96], w3 = [31:0]; captured in the start cycle
- rk  out  128  current round key, same byte order as key_in
- rk_round  out  4  round index of rk, 0..10
- rk_valid  out  1  rk/rk_round valid
- rk_ready  in  1  consumer accepts rk when rk_valid && rk_ready
- busy  out  1  high from the cycle after start acceptance through the final handshake cycle
- done  out  1  one-cycle pulse in the cycle after round 10 is accepted

## Operation
- States: IDLE, PRESENT (rk_valid=1, waiting for handshake), SUB (4 cycles, byte counter 0..3).
- IDLE: start=1 -> rk<=key_in, rk_round<=0, go PRESENT. start while not IDLE is ignored.
- PRESENT: rk, rk_round held stable while !rk_ready. On handshake: if rk_round==10 -> IDLE, pulse done; else -> SUB, counter<=0.
- SUB: counter c selects byte of RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}; S-box(byte c) stored in temp byte c (c=0 is most significant). One S-box instance, FIPS-197 table.
- On the SUB cycle with c==3, using the registered temp bytes 0..2 plus the combinational S-box output for byte 3:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}, where r = rk_round+1.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rk <= {w0',w1',w2',w3'}, rk_round <= r, go PRESENT.
- Rcon for r=1..10: 01,02,04,08,10,20,40,80,1B,36.
- All XORs are bitwise over 8 or 32 bits; there is no carry and no width growth.
- The S-box counter is 2 bits and wraps only by leaving SUB at c==3.

## Timing
- Reset value of every output is 0: rk, rk_round, rk_valid, busy, done. State resets to IDLE and the counter to 0.
- rst has priority over all other inputs in every state. Reset mid-expansion aborts the expansion with no done pulse; the next start restarts from round 0.
- Start accepted in cycle T -> round 0 valid in cycle T+1.
- Handshake in cycle C for round r<10:
  - rk_valid=0 in cycles C+1..C+4 (SUB).
  - Round r+1 is valid in cycle C+5.
- With rk_ready tied high:
  - Round r is valid in cycle T+1+5r.
  - Round 10 is valid in cycle T+51.
  - done and busy=0 in cycle T+52.
- done is in the same cycle as the return to IDLE. A start in that cycle is accepted.
- After completion rk and rk_round keep their round-10 values until the next start or rst. rk_valid stays 0.
- rk_ready is ignored while rk_valid=0.

## Test plan
- FIPS-197 A.1, with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1:
  - Round 0 equals key_in in cycle T+1.
  - Round 1 = a0fafe1788542cb123a339392a6c7605 in cycle T+6.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle T+51.
  - done pulses once in cycle T+52.
- Backpressure: hold rk_ready=0 for 7 cycles on round 3, then raise it.
  - rk and rk_round=3 stay stable and rk_valid stays 1 throughout.
  - Round 4 appears 5 cycles after the handshake with the correct value.
  - Total expansion takes 7 cycles longer than the tied-high run.
- Key all-zero: round 1 = 62636363626363636263636362636363 and round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start pulsed during SUB and PRESENT is ignored: the key sequence is unchanged and there is no restart.
- Reset asserted in round 5 SUB (c==2):
  - All outputs are 0 in the next cycle, with no done pulse.
  - A new start (A.1 key) reproduces the full sequence from round 0.
- Back-to-back: assert start in the done cycle with a second key. Round 0 of the new key is valid the next cycle, and both 11-key sequences are correct.
